seg_display_scan: RTL

Multiplexed 8-digit seven-segment display driver: the reader side of the CPU's display/statistics outputs. It selects one of four 32-bit CPU result words (syscall display, cycle count, predict-success count, predict-fail count). It latches that word coherently once per scan frame and time-multiplexes its eight hex nibbles onto shared active-low segment lines. It sits at board top level, between the `cpu` outputs and the FPGA display pins.

---
 rtl/display_pkg.sv | 22 ++
 rtl/hex7seg.sv | 11 +
 rtl/seg_display_scan.sv | 104 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path: source selects,
// blank code and the active-low hex font (bit order g,f,e,d,c,b,a).
package display_pkg;

  typedef enum logic [1:0] {
    SEL_DISP      = 2'd0,
    SEL_CYCLE     = 2'd1,
    SEL_PRED_OK   = 2'd2,
    SEL_PRED_FAIL = 2'd3
  } sel_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low hex font, indexed by nibble value.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment code.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nib];

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed 8-digit seven-segment scanner. One of four 32-bit words is
// latched once per scan frame and its nibbles are shown one digit at a time.
module seg_display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic [31:0] disp_data,
  input  logic [31:0] cycle_cnt,
  input  logic [31:0] pred_ok,
  input  logic [31:0] pred_fail,
  input  logic [1:0]  sel,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       idx;
  logic             frame_end;
  logic [31:0]      snap;
  logic [31:0]      src_word;
  logic [31:0]      upper;
  logic [3:0]       nibble;
  logic [6:0]       font_code;
  logic             blank;

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (idx == 3'd7);

  // Source word selection; only sampled at the frame boundary.
  always_comb begin
    src_word = disp_data;
    case (sel_e'(sel))
      SEL_DISP:      src_word = disp_data;
      SEL_CYCLE:     src_word = cycle_cnt;
      SEL_PRED_OK:   src_word = pred_ok;
      SEL_PRED_FAIL: src_word = pred_fail;
      default:       src_word = disp_data;
    endcase
  end

  // Shifting the snapshot down by the digit position gives both the nibble
  // to show (low 4 bits) and the leading-zero test (whole remainder zero).
  assign upper  = snap >> {idx, 2'b00};
  assign nibble = upper[3:0];
  assign blank  = blank_lz && (idx != 3'd0) && (upper == 32'd0);

  hex7seg u_hex7seg (
    .nib (nibble),
    .seg (font_code)
  );

  // Digit-slot divider: counts 0..SCAN_DIV-1 and wraps on tick.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Digit index advances once per slot, wrapping 7 -> 0 naturally.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      idx <= 3'd0;
    end else if (tick) begin
      idx <= idx + 3'd1;
    end
  end

  // Coherent per-frame snapshot; freeze holds the current word.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      snap <= 32'd0;
    end else if (frame_end && !freeze) begin
      snap <= src_word;
    end
  end

  // Output stage: an/seg/dp registered together so they never disagree.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'h01 << idx);
      seg <= blank ? SEG_BLANK : font_code;
      dp  <= ~(freeze && (idx == 3'd0));
    end
  end

endmodule
